// File: rtl/alu_exec.sv
// Multi-cycle ALU: single-cycle logic/arith ops, bit-serial shifts, optional shift-add multiply.
// Define ALU_EXEC_MUL_EN to build the MUL state and multiply datapath (op code 11).
module alu_exec (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  operation,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StMul   = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpSub = 4'd1;
    localparam logic [3:0] OpSll = 4'd2;
    localparam logic [3:0] OpLt  = 4'd3;
    localparam logic [3:0] OpLtu = 4'd4;
    localparam logic [3:0] OpXor = 4'd5;
    localparam logic [3:0] OpSrl = 4'd6;
    localparam logic [3:0] OpSra = 4'd7;
    localparam logic [3:0] OpOr  = 4'd8;
    localparam logic [3:0] OpAnd = 4'd9;
    localparam logic [3:0] OpEq  = 4'd10;
    localparam logic [3:0] OpMul = 4'd11;

    logic [1:0]  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] work_q, work_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic [31:0] alu_res;
    logic [31:0] shift_step;

`ifdef ALU_EXEC_MUL_EN
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] acc_next;

    assign acc_next = acc_q + (mplier_q[0] ? work_q : 32'd0);
`endif

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = zero_q;

    always_comb begin
        alu_res = 32'd0;
        case (operation)
            OpAdd:   alu_res = op_a + op_b;
            OpSub:   alu_res = op_a - op_b;
            OpLt:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            OpLtu:   alu_res = {31'd0, op_a < op_b};
            OpXor:   alu_res = op_a ^ op_b;
            OpOr:    alu_res = op_a | op_b;
            OpAnd:   alu_res = op_a & op_b;
            OpEq:    alu_res = {31'd0, op_a == op_b};
            default: alu_res = 32'd0;
        endcase
    end

    // SRA replicates bit 31, which never changes while shifting right arithmetically.
    always_comb begin
        shift_step = work_q;
        case (op_q)
            OpSll:   shift_step = {work_q[30:0], 1'b0};
            OpSrl:   shift_step = {1'b0, work_q[31:1]};
            OpSra:   shift_step = {work_q[31], work_q[31:1]};
            default: shift_step = work_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        result_d = result_q;
`ifdef ALU_EXEC_MUL_EN
        mplier_d = mplier_q;
        acc_d    = acc_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d = operation;
                    case (operation)
                        OpSll, OpSrl, OpSra: begin
                            if (op_b[4:0] == 5'd0) begin
                                result_d = op_a;
                                state_d  = StDone;
                            end else begin
                                work_d  = op_a;
                                cnt_d   = op_b[4:0];
                                state_d = StShift;
                            end
                        end
`ifdef ALU_EXEC_MUL_EN
                        OpMul: begin
                            work_d   = op_a;
                            mplier_d = op_b;
                            acc_d    = 32'd0;
                            cnt_d    = 5'd31;
                            state_d  = StMul;
                        end
`endif
                        default: begin
                            result_d = alu_res;
                            state_d  = StDone;
                        end
                    endcase
                end
            end
            StShift: begin
                work_d = shift_step;
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    result_d = shift_step;
                    state_d  = StDone;
                end
            end
`ifdef ALU_EXEC_MUL_EN
            StMul: begin
                acc_d    = acc_next;
                work_d   = {work_q[30:0], 1'b0};
                mplier_d = {1'b0, mplier_q[31:1]};
                cnt_d    = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    result_d = acc_next;
                    state_d  = StDone;
                end
            end
`endif
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        zero_d = (result_d == 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= OpAdd;
            work_q   <= 32'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
            zero_q   <= 1'b1;
`ifdef ALU_EXEC_MUL_EN
            mplier_q <= 32'd0;
            acc_q    <= 32'd0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifdef ALU_EXEC_MUL_EN
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec; inputs driven and outputs sampled on negedge.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  operation;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_exec dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Present one request for a single edge; returns at the first negedge after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        operation = op;
        op_a      = a;
        op_b      = b;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // Latency in cycles from accept edge to out_valid seen; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (result !== 32'd0) begin n_fail++;
            $display("FAIL reset_result: got %h want 0", result); end
        n_cmp++; if (zero !== 1'b1) begin n_fail++;
            $display("FAIL reset_zero: got %b want 1", zero); end
    endtask

    task automatic test_add();
        int lat;
        issue(4'd0, 32'hFFFF_FFFF, 32'd1);
        wait_done(lat);
        n_cmp++; if (lat !== 1) begin n_fail++;
            $display("FAIL add_wrap_latency: got %0d want 1", lat); end
        n_cmp++; if (result !== 32'd0) begin n_fail++;
            $display("FAIL add_wrap_result: got %h want 0", result); end
        n_cmp++; if (zero !== 1'b1) begin n_fail++;
            $display("FAIL add_wrap_zero: got %b want 1", zero); end
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++;
            $display("FAIL add_return_idle: got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
        issue(4'd0, 32'd3, 32'd4);
        wait_done(lat);
        n_cmp++; if (result !== 32'd7 || zero !== 1'b0 || lat !== 1) begin n_fail++;
            $display("FAIL add_3_4: got %h z=%b lat=%0d want 7 z=0 lat=1", result, zero, lat); end
    endtask

    task automatic test_shift();
        int lat;
        logic [3:0]  ops  [5] = '{4'd7, 4'd6, 4'd2, 4'd2, 4'd7};
        logic [31:0] as   [5] = '{32'h8000_0000, 32'h8000_0000, 32'h3, 32'hDEAD_BEEF,
                                  32'h7000_0000};
        logic [31:0] bs   [5] = '{32'h24, 32'h4, 32'h21, 32'h20, 32'h1};
        logic [31:0] exps [5] = '{32'hF800_0000, 32'h0800_0000, 32'h6, 32'hDEAD_BEEF,
                                  32'h3800_0000};
        int          lats [5] = '{5, 5, 2, 1, 2};
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(lat);
            n_cmp++; if (lat !== lats[i]) begin n_fail++;
                $display("FAIL shift%0d_latency: got %0d want %0d", i, lat, lats[i]); end
            n_cmp++; if (result !== exps[i] || zero !== 1'b0) begin n_fail++;
                $display("FAIL shift%0d_result: got %h z=%b want %h z=0", i, result, zero,
                         exps[i]); end
        end
    endtask

    task automatic test_compare();
        int lat;
        logic [3:0]  ops  [9] = '{4'd3, 4'd4, 4'd10, 4'd5, 4'd8, 4'd9, 4'd1, 4'd12, 4'd10};
        logic [31:0] as   [9] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd5, 32'hF0F0_F0F0,
                                  32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'd0, 32'd9, 32'd5};
        logic [31:0] bs   [9] = '{32'd1, 32'd1, 32'd5, 32'hFF00_FF00, 32'hFF00_FF00,
                                  32'hFF00_FF00, 32'd1, 32'd9, 32'd6};
        logic [31:0] exps [9] = '{32'd1, 32'd0, 32'd1, 32'h0FF0_0FF0, 32'hFFF0_FFF0,
                                  32'hF000_F000, 32'hFFFF_FFFF, 32'd0, 32'd0};
        for (int i = 0; i < 9; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(lat);
            n_cmp++; if (lat !== 1 || result !== exps[i] || zero !== (exps[i] == 32'd0))
            begin n_fail++;
                $display("FAIL cmp%0d: got %h z=%b lat=%0d want %h lat=1", i, result, zero,
                         lat, exps[i]); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        issue(4'd1, 32'd7, 32'd7);
        wait_done(lat);
        n_cmp++; if (lat !== 1) begin n_fail++;
            $display("FAIL bp_latency: got %0d want 1", lat); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b1 ||
                         in_ready !== 1'b0) begin n_fail++;
                $display("FAIL bp_hold%0d: got vld=%b res=%h z=%b rdy=%b want 1/0/1/0", i,
                         out_valid, result, zero, in_ready); end
            operation = 4'd0;
            op_a      = 32'd1;
            op_b      = 32'd1;
            in_valid  = (i % 2 == 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0) begin
            n_fail++;
            $display("FAIL bp_release: got vld=%b rdy=%b res=%h want 0/1/0", out_valid,
                     in_ready, result); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++;
            $display("FAIL bp_pulse_ignored: got vld=%b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic seen_valid;
        issue(4'd0, 32'd5, 32'd6);
        wait_done(lat);
        n_cmp++; if (result !== 32'd11) begin n_fail++;
            $display("FAIL pre_reset_add: got %h want 0000000b", result); end
        issue(4'd2, 32'd1, 32'd31);
        seen_valid = out_valid;
        for (int c = 2; c < 10; c++) begin
            @(negedge clk);
            seen_valid |= out_valid;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (seen_valid !== 1'b0) begin n_fail++;
            $display("FAIL shift_early_valid: got %b want 0", seen_valid); end
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 ||
                     zero !== 1'b1) begin n_fail++;
            $display("FAIL mid_shift_reset: got rdy=%b vld=%b res=%h z=%b want 1/0/0/1",
                     in_ready, out_valid, result, zero); end
        seen_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen_valid |= out_valid;
        end
        n_cmp++; if (seen_valid !== 1'b0) begin n_fail++;
            $display("FAIL discarded_shift_valid: got %b want 0", seen_valid); end
        out_ready = 1'b0;
        issue(4'd0, 32'd1, 32'd2);
        wait_done(lat);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0 ||
                     zero !== 1'b1) begin n_fail++;
            $display("FAIL done_reset: got vld=%b rdy=%b res=%h z=%b want 0/1/0/1",
                     out_valid, in_ready, result, zero); end
    endtask

    task automatic test_mul();
        int lat;
        logic [31:0] as [3] = '{32'h0001_0001, 32'hFFFF_FFFF, 32'd7};
        logic [31:0] bs [3] = '{32'h0001_0001, 32'hFFFF_FFFF, 32'd6};
`ifdef ALU_EXEC_MUL_EN
        logic [31:0] exps [3] = '{32'h0002_0001, 32'd1, 32'd42};
        int mul_lat = 33;
`else
        logic [31:0] exps [3] = '{32'd0, 32'd0, 32'd0};
        int mul_lat = 1;
`endif
        for (int i = 0; i < 3; i++) begin
            issue(4'd11, as[i], bs[i]);
            wait_done(lat);
            n_cmp++; if (lat !== mul_lat) begin n_fail++;
                $display("FAIL mul%0d_latency: got %0d want %0d", i, lat, mul_lat); end
            n_cmp++; if (result !== exps[i] || zero !== (exps[i] == 32'd0)) begin n_fail++;
                $display("FAIL mul%0d_result: got %h z=%b want %h", i, result, zero,
                         exps[i]); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        operation = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        test_reset();
        test_add();
        test_shift();
        test_compare();
        test_backpressure();
        test_reset_mid();
        test_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL have ports: in_valid  input  1  request valid; in_ready  output  1  block can accept.
REQ-004 SHALL have ports: operation  input  4  ALU op code from alu_control; op_a  input  32  rs1/PC; op_b  input  32  rs2/immediate.
REQ-005 SHALL have ports: out_valid  output  1  result valid; out_ready  input  1  consumer accepts result.
REQ-006 SHALL have ports: result  output  32  registered result; zero  output  1  registered (result == 0).
REQ-007 SHALL decode operation as: ADD=0, SUB=1, SLL=2, LT=3, LTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, EQ=10, MUL=11 (MUL only per REQ-021).

Function
REQ-008 SHALL implement a state machine with states IDLE, SHIFT, MUL, DONE; in_ready = 1 only in IDLE.
REQ-009 SHALL accept a request only on a cycle with in_valid && in_ready, capturing operation, op_a, op_b; inputs ignored otherwise.
REQ-010 SHALL, for ADD, SUB, LT, LTU, XOR, OR, AND, EQ and undefined codes, load result and enter DONE on the accept edge (out_valid high the next cycle, latency 1).
REQ-011 SHALL compute ADD/SUB modulo 2^32; LT signed, LTU unsigned, EQ (a == b), each as 0/1 zero-extended to 32 bits; undefined codes give 0.
REQ-012 SHALL, for SLL/SRL/SRA, use shamt = op_b[4:0] only, and shift the working register by one bit per cycle in SHIFT with a 5-bit down-counter.
REQ-013 SHALL, for shamt = 0, enter DONE directly with result = op_a (latency 1); for shamt = N > 0, raise out_valid N+1 cycles after accept.
REQ-014 SHALL fill SRA vacated bits with captured op_a[31], and SLL/SRL vacated bits with 0.
REQ-015 SHALL in DONE hold out_valid = 1 and result/zero stable until out_valid && out_ready, then return to IDLE on that edge.
REQ-016 SHALL NOT accept a new request in the DONE-to-IDLE cycle (one idle bubble minimum between results).
REQ-017 SHALL keep zero equal to (result == 0) at all times, including during reset.
REQ-018 SHALL keep out_valid low in IDLE, SHIFT and MUL; result holds its last value outside DONE.

Reset
REQ-019 SHALL on rst = 1 at a rising edge enter IDLE, clear counters, set result = 0, zero = 1, out_valid = 0, in_ready = 1 the following cycle.
REQ-020 SHALL, when rst asserts mid-SHIFT, mid-MUL or in DONE, discard the operation with no out_valid pulse; rst has priority over acceptance and out_ready.

Configuration
REQ-021 SHALL with macro ALU_EXEC_MUL_EN defined implement MUL=11: shift-add in MUL state, one bit of op_b per cycle, exactly 32 cycles, result = low 32 bits of op_a*op_b, out_valid 33 cycles after accept.
REQ-022 SHALL without ALU_EXEC_MUL_EN treat code 11 as undefined (result 0, latency 1), with no MUL state or multiply datapath synthesized.

Verification
REQ-023 SHALL cover: reset then ADD op_a=0xFFFFFFFF, op_b=1, out_ready=1 -> out_valid 1 cycle later, result=0, zero=1, in_ready back high one cycle after.
REQ-024 SHALL cover: SRA op_a=0x80000000, op_b=0x00000024 (shamt 4) -> out_valid 5 cycles after accept, result=0xF8000000, zero=0.
REQ-025 SHALL cover: LT op_a=0xFFFFFFFE, op_b=1 -> result=1; LTU same operands -> result=0; EQ 5,5 -> result=1.
REQ-026 SHALL cover: SUB 7-7 with out_ready=0 for 4 cycles -> out_valid, result=0, zero=1 held stable, in_ready=0 throughout, in_valid pulses ignored.
REQ-027 SHALL cover: SLL op_a=1, shamt 31, rst pulsed at cycle 10 -> no out_valid, result=0, in_ready=1 the cycle after reset.
REQ-028 SHALL cover (ALU_EXEC_MUL_EN): MUL 0x00010001 x 0x00010001 -> result=0x00020001 at 33 cycles; without macro same stimulus -> result=0 at 1 cycle.
